// File: rtl/encrypt_config.sv
// Shared types and constants for the encrypted-byte word packer.
package encrypt_config;

  localparam int unsigned PACK_LANES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } enc_word_t;

endpackage

// File: rtl/encrypt_sync_fifo.sv
// First-word-fall-through FIFO of packed words. Pushes while full succeed only
// when a pop happens in the same cycle; otherwise they are ignored.
module encrypt_sync_fifo
  import encrypt_config::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  enc_word_t              wdata_i,
  input  logic                   pop_i,
  output enc_word_t              rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  enc_word_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Decode accepted push/pop and compute next pointers and occupancy.
  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == LW'(DEPTH));
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + LW'(1);
    if (!do_push && do_pop) count_d = count_q - LW'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are masked at the output while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head entry falls through; drive zeros when nothing is buffered.
  always_comb begin
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    level_o = count_q;
  end

endmodule

// File: rtl/encrypt_word_packer.sv
// Packs the encrypted byte stream into 32-bit words with keep/last marking and
// buffers them for the bus side. Words lost to a full FIFO set a sticky flag.
module encrypt_word_packer
  import encrypt_config::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BYTE_ORDER = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  din,
  input  logic                        din_v,
  input  logic                        flush,
  output logic [31:0]                 dout,
  output logic [PACK_LANES-1:0]       dout_keep,
  output logic                        dout_last,
  output logic                        dout_v,
  input  logic                        dout_rdy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  logic [1:0]            idx_q, idx_d;
  logic [31:0]           stage_q, stage_d;
  logic [PACK_LANES-1:0] keep_q, keep_d;
  logic                  overflow_q, overflow_d;

  logic [1:0]            lane;
  logic [31:0]           word_nxt;
  logic [PACK_LANES-1:0] keep_nxt;
  logic                  push;
  enc_word_t             push_word;
  enc_word_t             head;
  logic                  fifo_full, fifo_empty, pop_fire;

  // Absorb the incoming byte first, then decide whether the result is pushed.
  // A flush always pushes: partial word, or a keep=0 terminator when empty.
  always_comb begin
    lane     = (BYTE_ORDER != 0) ? (2'd3 - idx_q) : idx_q;
    word_nxt = stage_q;
    keep_nxt = keep_q;
    if (din_v) begin
      word_nxt[{lane, 3'b000} +: 8] = din;
      keep_nxt[lane]                = 1'b1;
    end
    push           = flush || (din_v && (idx_q == 2'd3));
    push_word.data = word_nxt;
    push_word.keep = keep_nxt;
    push_word.last = flush;

    idx_d   = idx_q;
    stage_d = stage_q;
    keep_d  = keep_q;
    if (push) begin
      idx_d   = 2'd0;
      stage_d = '0;
      keep_d  = '0;
    end else if (din_v) begin
      idx_d   = idx_q + 2'd1;
      stage_d = word_nxt;
      keep_d  = keep_nxt;
    end

    pop_fire   = dout_rdy && !fifo_empty;
    overflow_d = overflow_q || (push && fifo_full && !pop_fire);
  end

  // Accumulator and sticky overflow state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      stage_q    <= '0;
      keep_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      keep_q     <= keep_d;
      overflow_q <= overflow_d;
    end
  end

  encrypt_sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (dout_rdy),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Present the FIFO head on the bus side.
  always_comb begin
    dout      = head.data;
    dout_keep = head.keep;
    dout_last = head.last;
    dout_v    = !fifo_empty;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_encrypt_word_packer.sv
// Directed bench for encrypt_word_packer (FIFO_DEPTH=4, BYTE_ORDER=0).
module tb_encrypt_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_v;
  logic        flush;
  logic [31:0] dout;
  logic [3:0]  dout_keep;
  logic        dout_last;
  logic        dout_v;
  logic        dout_rdy;
  logic        overflow;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  encrypt_word_packer #(
    .FIFO_DEPTH(4),
    .BYTE_ORDER(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_v     (din_v),
    .flush     (flush),
    .dout      (dout),
    .dout_keep (dout_keep),
    .dout_last (dout_last),
    .dout_v    (dout_v),
    .dout_rdy  (dout_rdy),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din   = b;
    din_v = 1'b1;
    tick();
    din_v = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
    check_eq({tag, ".v"},    64'(dout_v), 64'd1);
    check_eq({tag, ".data"}, 64'(dout), 64'(d));
    check_eq({tag, ".keep"}, 64'(dout_keep), 64'(k));
    check_eq({tag, ".last"}, 64'(dout_last), 64'(l));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".v"},     64'(dout_v), 64'd0);
    check_eq({tag, ".data"},  64'(dout), 64'd0);
    check_eq({tag, ".keep"},  64'(dout_keep), 64'd0);
    check_eq({tag, ".last"},  64'(dout_last), 64'd0);
    check_eq({tag, ".level"}, 64'(level), 64'd0);
    check_eq({tag, ".ovf"},   64'(overflow), 64'd0);
  endtask

  logic [31:0] w [5];

  initial begin
    w[0] = 32'h1000_0001; w[1] = 32'h2000_0002; w[2] = 32'h3000_0003;
    w[3] = 32'h4000_0004; w[4] = 32'h5000_0005;
    rst = 1'b0; din = '0; din_v = 1'b0; flush = 1'b0; dout_rdy = 1'b0;
    tick(); tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // Four bytes make one full word, visible the cycle after the last byte.
    dout_rdy = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check_head("full_word", 32'h4433_2211, 4'hF, 1'b0);
    check_eq("full_word.level", 64'(level), 64'd1);
    tick();
    check_eq("full_word.gone", 64'(dout_v), 64'd0);

    // Partial word closed by a lone flush, then realignment to lane 0.
    send_byte(8'hA1); send_byte(8'hB2);
    do_flush();
    check_head("partial2", 32'h0000_B2A1, 4'b0011, 1'b1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check_head("realign", 32'h0403_0201, 4'hF, 1'b0);
    tick();

    // Byte and flush together, then terminator from an empty accumulator.
    send_byte(8'hA1); send_byte(8'hB2);
    din = 8'hC3; din_v = 1'b1; flush = 1'b1;
    tick();
    din_v = 1'b0; flush = 1'b0;
    check_head("partial3", 32'h00C3_B2A1, 4'b0111, 1'b1);
    do_flush();
    check_head("term", 32'h0, 4'h0, 1'b1);
    tick();
    check_eq("term.gone", 64'(dout_v), 64'd0);

    // Overflow: five words into a four-deep FIFO with no consumer.
    dout_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    check_eq("fill.level", 64'(level), 64'd4);
    check_eq("fill.ovf", 64'(overflow), 64'd0);
    send_word(w[4]);
    check_eq("ovf.level", 64'(level), 64'd4);
    check_eq("ovf.flag", 64'(overflow), 64'd1);
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), w[i], 4'hF, 1'b0);
      tick();
    end
    check_eq("drain.empty", 64'(dout_v), 64'd0);
    check_eq("drain.ovf_sticky", 64'(overflow), 64'd1);

    // Reset clears the sticky flag.
    rst = 1'b0;
    #1;
    check_eq("rst.ovf", 64'(overflow), 64'd0);
    rst = 1'b1;
    tick();

    // Full FIFO with a push and pop on the same edge.
    dout_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    send_byte(w[4][7:0]); send_byte(w[4][15:8]); send_byte(w[4][23:16]);
    dout_rdy = 1'b1;
    send_byte(w[4][31:24]);
    dout_rdy = 1'b0;
    check_eq("pushpop.level", 64'(level), 64'd4);
    check_eq("pushpop.ovf", 64'(overflow), 64'd0);
    dout_rdy = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("pp_drain%0d", i), w[i], 4'hF, 1'b0);
      tick();
    end
    check_eq("pp_drain.empty", 64'(dout_v), 64'd0);

    // Asynchronous reset mid-frame with buffered words.
    dout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send_word(w[i]);
    send_byte(8'hEE); send_byte(8'hFF);
    check_eq("pre_rst.level", 64'(level), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    check_idle("midrst");
    #2;
    rst = 1'b1;
    tick();
    dout_rdy = 1'b1;
    send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_byte(8'h8D);
    check_head("post_rst", 32'h8D7C_6B5A, 4'hF, 1'b0);
    check_eq("post_rst.level", 64'(level), 64'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
